// File: rtl/chacha_pkg.sv
// Shared constants, encodings and helpers for the ChaCha keystream stream generator.
package chacha_pkg;

  localparam logic [127:0] SIGMA = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

  typedef enum logic [1:0] {
    SEL_KEY   = 2'd0,
    SEL_NONCE = 2'd1,
    SEL_CTR   = 2'd2,
    SEL_NONE  = 2'd3
  } sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  localparam int unsigned KEY_LEN        = 32;
  localparam int unsigned IETF_CTR_LEN   = 4;
  localparam int unsigned IETF_NONCE_LEN = 12;
  localparam int unsigned DJB_CTR_LEN    = 8;
  localparam int unsigned DJB_NONCE_LEN  = 8;

  localparam int unsigned W_KEY0        = 4;
  localparam int unsigned W_CTR         = 12;
  localparam int unsigned W_NONCE0_IETF = 13;
  localparam int unsigned W_NONCE0_DJB  = 14;
  localparam int unsigned CFG_WORDS     = 12;

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

endpackage

// File: rtl/chacha_qr.sv
// Combinational ChaCha quarter-round on four 32-bit words.
module chacha_qr
  import chacha_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  output logic [31:0] qa,
  output logic [31:0] qb,
  output logic [31:0] qc,
  output logic [31:0] qd
);

  logic [31:0] a1_s, b1_s, c1_s, d1_s;

  assign a1_s = a + b;
  assign d1_s = rotl32(d ^ a1_s, 16);
  assign c1_s = c + d1_s;
  assign b1_s = rotl32(b ^ c1_s, 12);
  assign qa   = a1_s + b1_s;
  assign qd   = rotl32(d1_s ^ qa, 8);
  assign qc   = c1_s + qd;
  assign qb   = rotl32(b1_s ^ qc, 7);

endmodule

// File: rtl/chacha_stream.sv
// Iterative ChaCha keystream generator with byte-addressed load bus and valid/ready output.
// CHACHA_CTR64_EN selects the 64-bit counter / 8-byte nonce layout; default is 32-bit / 12-byte.
module chacha_stream
  import chacha_pkg::*;
#(
  parameter int unsigned ROUNDS = 20,
  parameter int unsigned BUS_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       in_sel,
  input  logic [BUS_W-1:0] in_data,
  output logic             in_ready,
  input  logic             start,
  input  logic             stream,
  input  logic             hold,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BUS_W-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

`ifdef CHACHA_CTR64_EN
  localparam bit CTR64 = 1'b1;
`else
  localparam bit CTR64 = 1'b0;
`endif

  localparam int unsigned NB         = BUS_W / 8;
  localparam int unsigned NBEATS     = 64 / NB;
  localparam int unsigned CI         = W_CTR - W_KEY0;
  localparam int unsigned CTR_LEN    = CTR64 ? DJB_CTR_LEN : IETF_CTR_LEN;
  localparam int unsigned NONCE_LEN  = CTR64 ? DJB_NONCE_LEN : IETF_NONCE_LEN;
  localparam int unsigned NONCE_BASE = ((CTR64 ? W_NONCE0_DJB : W_NONCE0_IETF) - W_KEY0) * 4;
  localparam logic [4:0]  LAST_RND   = 5'(ROUNDS - 1);

  state_e       state_r, state_nxt_s;
  logic [4:0]   rnd_r;
  logic [31:0]  x_r      [16];
  logic [31:0]  x_rnd_s  [16];
  logic [31:0]  init_s   [16];
  logic [31:0]  cfg_r    [CFG_WORDS];
  logic [31:0]  cfg_nxt_s[CFG_WORDS];
  logic [5:0]   ptr_r, ptr_nxt_s, eff_ptr_s, end_ptr_s, fbase_s, flen_s, wr_addr_s;
  logic         wr_en_s;
  logic [1:0]   prev_sel_r;
  logic [511:0] obuf_r, sum_s;
  logic [5:0]   ocnt_r;
  logic         in_ready_r, out_valid_r, out_last_r, busy_r;
  logic         ld_acc_s, beat_acc_s, last_acc_s, diag_s;
  logic [31:0]  qa_i[4], qb_i[4], qc_i[4], qd_i[4];
  logic [31:0]  qa_o[4], qb_o[4], qc_o[4], qd_o[4];

  assign ld_acc_s   = in_valid & in_ready_r;
  assign beat_acc_s = out_valid_r & out_ready;
  assign last_acc_s = beat_acc_s & out_last_r;
  assign diag_s     = rnd_r[0];

  // Load pointer and field decode for the current beat
  always_comb begin
    eff_ptr_s = (in_sel == prev_sel_r) ? ptr_r : 6'd0;
    wr_en_s   = 1'b1;
    case (sel_e'(in_sel))
      SEL_KEY:   begin fbase_s = 6'd0;            flen_s = 6'(KEY_LEN);   end
      SEL_NONCE: begin fbase_s = 6'(NONCE_BASE);  flen_s = 6'(NONCE_LEN); end
      SEL_CTR:   begin fbase_s = 6'(CI * 4);      flen_s = 6'(CTR_LEN);   end
      default:   begin fbase_s = 6'd0;            flen_s = 6'd0; wr_en_s = 1'b0; end
    endcase
    end_ptr_s = eff_ptr_s + 6'(NB);
    if (wr_en_s && (end_ptr_s < flen_s)) begin
      ptr_nxt_s = end_ptr_s;
    end else begin
      ptr_nxt_s = 6'd0;
    end
  end

  // Next key/nonce/counter image: host writes in IDLE, counter bump after a block
  always_comb begin
    cfg_nxt_s = cfg_r;
    wr_addr_s = 6'd0;
    if (ld_acc_s && wr_en_s) begin
      for (int k = 0; k < NB; k++) begin
        wr_addr_s = fbase_s + eff_ptr_s + 6'(k);
        cfg_nxt_s[wr_addr_s[5:2]][{wr_addr_s[1:0], 3'b000} +: 8] = in_data[8*k +: 8];
      end
    end else if (last_acc_s) begin
`ifdef CHACHA_CTR64_EN
      {cfg_nxt_s[CI+1], cfg_nxt_s[CI]} = {cfg_r[CI+1], cfg_r[CI]} + 64'd1;
`else
      cfg_nxt_s[CI] = cfg_r[CI] + 32'd1;
`endif
    end else begin
      cfg_nxt_s = cfg_r;
    end
  end

  // Block input state built from the post-write image so a same-cycle write is included
  always_comb begin
    for (int i = 0; i < 4; i++) init_s[i] = SIGMA[32*i +: 32];
    for (int i = 0; i < CFG_WORDS; i++) init_s[i+4] = cfg_nxt_s[i];
  end

  for (genvar q = 0; q < 4; q++) begin : g_qr
    localparam int unsigned BD = 4 + ((q + 1) % 4);
    localparam int unsigned CD = 8 + ((q + 2) % 4);
    localparam int unsigned DD = 12 + ((q + 3) % 4);
    assign qa_i[q] = x_r[q];
    assign qb_i[q] = diag_s ? x_r[BD] : x_r[4+q];
    assign qc_i[q] = diag_s ? x_r[CD] : x_r[8+q];
    assign qd_i[q] = diag_s ? x_r[DD] : x_r[12+q];
    chacha_qr u_qr (
      .a(qa_i[q]), .b(qb_i[q]), .c(qc_i[q]), .d(qd_i[q]),
      .qa(qa_o[q]), .qb(qb_o[q]), .qc(qc_o[q]), .qd(qd_o[q])
    );
  end

  // Route quarter-round results back to column or diagonal positions
  always_comb begin
    x_rnd_s = x_r;
    for (int q = 0; q < 4; q++) begin
      x_rnd_s[q] = qa_o[q];
      if (diag_s) begin
        x_rnd_s[4 + ((q + 1) % 4)]  = qb_o[q];
        x_rnd_s[8 + ((q + 2) % 4)]  = qc_o[q];
        x_rnd_s[12 + ((q + 3) % 4)] = qd_o[q];
      end else begin
        x_rnd_s[4 + q]  = qb_o[q];
        x_rnd_s[8 + q]  = qc_o[q];
        x_rnd_s[12 + q] = qd_o[q];
      end
    end
  end

  // Feed-forward sum of working state and input state
  always_comb begin
    sum_s = '0;
    for (int i = 0; i < 4; i++) sum_s[32*i +: 32] = x_r[i] + SIGMA[32*i +: 32];
    for (int i = 0; i < CFG_WORDS; i++) sum_s[32*(i+4) +: 32] = x_r[i+4] + cfg_r[i];
  end

  // FSM next-state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_ROUND;
        else       state_nxt_s = ST_IDLE;
      end
      ST_ROUND: begin
        if (hold)                 state_nxt_s = ST_ROUND;
        else if (rnd_r == LAST_RND) state_nxt_s = ST_FINAL;
        else                      state_nxt_s = ST_ROUND;
      end
      ST_FINAL: begin
        if (hold) state_nxt_s = ST_FINAL;
        else      state_nxt_s = ST_OUT;
      end
      ST_OUT: begin
        if (last_acc_s) state_nxt_s = stream ? ST_ROUND : ST_IDLE;
        else            state_nxt_s = ST_OUT;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // Working state and round counter
  always_ff @(posedge clk) begin
    if (rst) begin
      rnd_r <= 5'd0;
      for (int i = 0; i < 16; i++) x_r[i] <= 32'd0;
    end else if ((state_r != ST_ROUND) && (state_nxt_s == ST_ROUND)) begin
      rnd_r <= 5'd0;
      x_r   <= init_s;
    end else if ((state_r == ST_ROUND) && !hold) begin
      rnd_r <= rnd_r + 5'd1;
      x_r   <= x_rnd_s;
    end
  end

  // Key/nonce/counter storage and load pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CFG_WORDS; i++) cfg_r[i] <= 32'd0;
      ptr_r      <= 6'd0;
      prev_sel_r <= 2'd0;
    end else begin
      cfg_r <= cfg_nxt_s;
      if (ld_acc_s) begin
        ptr_r      <= ptr_nxt_s;
        prev_sel_r <= in_sel;
      end
    end
  end

  // Output buffer shifts down one beat per accepted transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      obuf_r     <= '0;
      ocnt_r     <= 6'd0;
      out_last_r <= 1'b0;
    end else if ((state_r == ST_FINAL) && !hold) begin
      obuf_r     <= sum_s;
      ocnt_r     <= 6'd0;
      out_last_r <= 1'b0;
    end else if (beat_acc_s) begin
      obuf_r     <= obuf_r >> BUS_W;
      ocnt_r     <= out_last_r ? 6'd0 : ocnt_r + 6'd1;
      out_last_r <= !out_last_r && ((ocnt_r + 6'd1) == 6'(NBEATS - 1));
    end
  end

  // Registered handshake/status flags decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      in_ready_r  <= (state_nxt_s == ST_IDLE);
      out_valid_r <= (state_nxt_s == ST_OUT);
      busy_r      <= (state_nxt_s != ST_IDLE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign busy      = busy_r;
  assign out_data  = obuf_r[BUS_W-1:0];

endmodule

// File: tb/tb_chacha_stream.sv
// Directed self-checking bench for chacha_stream (8-bit and 32-bit bus instances).
module tb_chacha_stream;

  localparam int R = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       in_valid = 1'b0, start = 1'b0, stream = 1'b0, hold = 1'b0, out_ready = 1'b0;
  logic [1:0] in_sel = 2'd0;
  logic [7:0] in_data = 8'd0, out_data;
  logic       in_ready, out_valid, out_last, busy;

  logic        w_in_valid = 1'b0, w_start = 1'b0, w_out_ready = 1'b0;
  logic [1:0]  w_in_sel = 2'd0;
  logic [31:0] w_in_data = 32'd0, w_out_data;
  logic        w_in_ready, w_out_valid, w_out_last, w_busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] rfc_blk [64] = '{
    8'h10, 8'hf1, 8'he7, 8'he4, 8'hd1, 8'h3b, 8'h59, 8'h15, 8'h50, 8'h0f, 8'hdd, 8'h1f, 8'ha3, 8'h20, 8'h71, 8'hc4,
    8'hc7, 8'hd1, 8'hf4, 8'hc7, 8'h33, 8'hc0, 8'h68, 8'h03, 8'h04, 8'h22, 8'haa, 8'h9a, 8'hc3, 8'hd4, 8'h6c, 8'h4e,
    8'hd2, 8'h82, 8'h64, 8'h46, 8'h07, 8'h9f, 8'haa, 8'h09, 8'h14, 8'hc2, 8'hd7, 8'h05, 8'hd9, 8'h8b, 8'h02, 8'ha2,
    8'hb5, 8'h12, 8'h9c, 8'hd1, 8'hde, 8'h16, 8'h4e, 8'hb9, 8'hcb, 8'hd0, 8'h83, 8'he8, 8'ha2, 8'h50, 8'h3c, 8'h4e};
  logic [7:0] zero_blk [8] = '{8'h76, 8'hb8, 8'he0, 8'had, 8'ha0, 8'hf1, 8'h3d, 8'h90};
  logic [7:0] rfc_nonce [12] = '{8'h00, 8'h00, 8'h00, 8'h09, 8'h00, 8'h00, 8'h00, 8'h4a, 8'h00, 8'h00, 8'h00, 8'h00};

  chacha_stream #(.ROUNDS(R), .BUS_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sel(in_sel), .in_data(in_data),
    .in_ready(in_ready), .start(start), .stream(stream), .hold(hold),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy));

  chacha_stream #(.ROUNDS(R), .BUS_W(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_sel(w_in_sel), .in_data(w_in_data),
    .in_ready(w_in_ready), .start(w_start), .stream(1'b0), .hold(1'b0),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
    .out_last(w_out_last), .busy(w_busy));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load8(input logic [1:0] sel, input logic [7:0] d, input logic with_start);
    in_valid = 1'b1; in_sel = sel; in_data = d; start = with_start;
    tick();
    in_valid = 1'b0; start = 1'b0;
  endtask

  task automatic load32(input logic [1:0] sel, input logic [31:0] d);
    w_in_valid = 1'b1; w_in_sel = sel; w_in_data = d;
    tick();
    w_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset8: got rdy=%b vld=%b last=%b busy=%b data=%02h required 1 0 0 0 00",
               in_ready, out_valid, out_last, busy, out_data);
    end
    checks++;
    if (w_in_ready !== 1'b1 || w_out_valid !== 1'b0 || w_out_last !== 1'b0 || w_busy !== 1'b0 || w_out_data !== 32'h0) begin
      errors++;
      $display("FAIL reset32: got rdy=%b vld=%b last=%b busy=%b data=%08h required 1 0 0 0 0",
               w_in_ready, w_out_valid, w_out_last, w_busy, w_out_data);
    end
  endtask

  task automatic test_rfc_vector();
    int n;
    for (int i = 0; i < 32; i++) load8(2'd0, 8'(i), 1'b0);
    for (int i = 0; i < 12; i++) load8(2'd1, rfc_nonce[i], 1'b0);
    load8(2'd2, 8'h01, 1'b0);
    for (int i = 0; i < 3; i++) load8(2'd2, 8'h00, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rfc_after_start: got in_ready=%b busy=%b required 0 1", in_ready, busy);
    end
    n = 0;
    while (!out_valid && n < 200) begin tick(); n++; end
    checks++;
    if (n + 1 != R + 2) begin
      errors++;
      $display("FAIL rfc_first_valid: got cycle %0d required %0d", n + 1, R + 2);
    end
    out_ready = 1'b1;
    for (int b = 0; b < 64; b++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== rfc_blk[b] || out_last !== (b == 63)) begin
        errors++;
        $display("FAIL rfc_beat[%0d]: got vld=%b data=%02h last=%b required 1 %02h %b",
                 b, out_valid, out_data, out_last, rfc_blk[b], (b == 63));
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rfc_return_idle: got vld=%b rdy=%b busy=%b required 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_bus32();
    int n;
    logic [31:0] exp_w;
    for (int k = 0; k < 8; k++) load32(2'd0, {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
    load32(2'd1, 32'h09000000);
    load32(2'd1, 32'h4a000000);
    load32(2'd1, 32'h00000000);
    load32(2'd2, 32'h00000001);
    w_start = 1'b1; tick(); w_start = 1'b0;
    n = 0;
    while (!w_out_valid && n < 200) begin tick(); n++; end
    checks++;
    if (n + 1 != R + 2) begin
      errors++;
      $display("FAIL bus32_first_valid: got cycle %0d required %0d", n + 1, R + 2);
    end
    checks++;
    if (w_out_data !== 32'he4e7f110) begin
      errors++;
      $display("FAIL bus32_beat0: got %08h required e4e7f110", w_out_data);
    end
    w_out_ready = 1'b1;
    for (int b = 0; b < 16; b++) begin
      exp_w = {rfc_blk[4*b+3], rfc_blk[4*b+2], rfc_blk[4*b+1], rfc_blk[4*b]};
      checks++;
      if (w_out_valid !== 1'b1 || w_out_data !== exp_w || w_out_last !== (b == 15)) begin
        errors++;
        $display("FAIL bus32_beat[%0d]: got vld=%b data=%08h last=%b required 1 %08h %b",
                 b, w_out_valid, w_out_data, w_out_last, exp_w, (b == 15));
      end
      tick();
    end
    w_out_ready = 1'b0;
    checks++;
    if (w_out_valid !== 1'b0 || w_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bus32_beat_count: got vld=%b rdy=%b after 16 beats required 0 1", w_out_valid, w_in_ready);
    end
  endtask

  task automatic test_hold_backpressure();
    int n;
    int b;
    int guard;
    logic rdy;
    load8(2'd2, 8'h01, 1'b0);
    for (int i = 0; i < 3; i++) load8(2'd2, 8'h00, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    tick(); tick(); n += 2;
    hold = 1'b1;
    repeat (5) begin tick(); n++; end
    hold = 1'b0;
    while (!out_valid && n < 200) begin tick(); n++; end
    checks++;
    if (n + 1 != R + 7) begin
      errors++;
      $display("FAIL hold_first_valid: got cycle %0d required %0d", n + 1, R + 7);
    end
    b = 0;
    guard = 0;
    while (b < 64 && guard < 2000) begin
      rdy = 1'($urandom_range(0, 1));
      out_ready = rdy;
      hold = 1'($urandom_range(0, 1));
      checks++;
      if (out_valid !== 1'b1 || out_data !== rfc_blk[b] || out_last !== (b == 63)) begin
        errors++;
        $display("FAIL bp_beat[%0d]: got vld=%b data=%02h last=%b required 1 %02h %b",
                 b, out_valid, out_data, out_last, rfc_blk[b], (b == 63));
      end
      tick();
      if (rdy) b++;
      guard++;
    end
    out_ready = 1'b0;
    hold = 1'b0;
    checks++;
    if (b != 64 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got beats=%0d vld=%b required 64 0", b, out_valid);
    end
  endtask

  task automatic test_reset_mid_round();
    int n;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    load8(2'd0, 8'hff, 1'b1);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_round_busy: got busy=%b rdy=%b required 1 0", busy, in_ready);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL mid_round_reset: got rdy=%b busy=%b vld=%b data=%02h last=%b required 1 0 0 00 0",
               in_ready, busy, out_valid, out_data, out_last);
    end
    start = 1'b1; tick(); start = 1'b0;
    tick();
    load8(2'd2, 8'h55, 1'b1);
    n = 2;
    while (!out_valid && n < 200) begin tick(); n++; end
    checks++;
    if (n != R + 1) begin
      errors++;
      $display("FAIL zero_first_valid: got %0d edges required %0d", n, R + 1);
    end
    out_ready = 1'b1;
    for (int b = 0; b < 64; b++) begin
      if (b < 8) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== zero_blk[b]) begin
          errors++;
          $display("FAIL zero_beat[%0d]: got vld=%b data=%02h required 1 %02h", b, out_valid, out_data, zero_blk[b]);
        end
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_return_idle: got rdy=%b vld=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_counter_wrap_stream();
    int n;
    stream = 1'b1;
    for (int i = 0; i < 3; i++) load8(2'd2, 8'hff, 1'b0);
    load8(2'd2, 8'hff, 1'b1);
    n = 0;
    while (!out_valid && n < 200) begin tick(); n++; end
    checks++;
    if (n != R + 1) begin
      errors++;
      $display("FAIL wrap_first_valid: got %0d edges required %0d", n, R + 1);
    end
    out_ready = 1'b1;
    for (int b = 0; b < 64; b++) begin
      if (b == 63) begin
        checks++;
        if (out_valid !== 1'b1 || out_last !== 1'b1) begin
          errors++;
          $display("FAIL wrap_blk1_last: got vld=%b last=%b required 1 1", out_valid, out_last);
        end
      end
      tick();
    end
    stream = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin tick(); n++; end
    checks++;
    if (n != R + 1) begin
      errors++;
      $display("FAIL stream_gap: got %0d cycles required %0d", n, R + 1);
    end
    for (int b = 0; b < 64; b++) begin
      if (b < 8) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== zero_blk[b]) begin
          errors++;
          $display("FAIL wrap_blk2_beat[%0d]: got vld=%b data=%02h required 1 %02h", b, out_valid, out_data, zero_blk[b]);
        end
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wrap_stop_stream: got vld=%b rdy=%b busy=%b required 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  initial begin
    test_reset();
    test_rfc_vector();
    test_bus32();
    test_hold_backpressure();
    test_reset_mid_round();
    test_counter_wrap_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chacha_stream.md
# chacha_stream

Parametrised ChaCha keystream generator: a successor to the fixed single-block core. Key, nonce and counter are loaded over a narrow write bus, and a configurable-round block is computed iteratively. The 64-byte keystream block is streamed out over a valid/ready port of configurable width. The counter auto-increments, so back-to-back blocks run without host intervention. It sits between the host byte interface and the downstream cipher/XOR datapath.

## Interface
- ROUNDS, 20, total rounds; even, 2..20 (8/12/20 are the supported variants).
- BUS_W, 8, width of the load and output buses; 8, 16 or 32.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  load beat present.
- in_sel  in  2  field select: 0 key, 1 nonce, 2 counter, 3 ignored.
- in_data  in  BUS_W  load data, byte 0 in bits [7:0].
- in_ready  out  1  high only in IDLE.
- start  in  1  begin a block (sampled in IDLE).
- stream  in  1  level; if high at the last output beat, the next block starts automatically.
- hold  in  1  freezes ROUND/FINAL progress.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts beat.
- out_data  out  BUS_W  keystream bytes, lowest-address byte in [7:0].
- out_last  out  1  final beat of a block.
- busy  out  1  high in any state except IDLE.

## Operation
- State: 16×32-bit words. Words 0–3 hold sigma "expand 32-byte k". Words 4–11 hold the key. Word 12 is the counter; words 13–15 are the nonce (12 bytes).
- All fields are little-endian: field byte 0 is the LSB of its first word.
- Load: a beat is accepted when in_valid && in_ready. It writes BUS_W/8 bytes at the field pointer, then advances the pointer.
- The pointer clears to 0 when in_sel differs from the previous accepted beat's in_sel. It wraps to 0 past the field end (32/12/4 bytes).
- FSM states and transitions:
  - IDLE → ROUND on start.
  - ROUND runs for ROUNDS cycles, alternating column (even cycles) and diagonal (odd cycles) rounds. Four quarter-rounds execute in parallel each cycle.
  - FINAL (1 cycle): the working state plus the input state is captured into the output buffer.
  - OUT streams 64/(BUS_W/8) beats.
  - After the last beat is accepted, the counter increments, mod 2^32.
  - From OUT: if stream is high → ROUND with the new counter; else → IDLE.
- Arithmetic: all adds are mod 2^32. Rotates are 16/12/8/7.
- out_data and out_last hold stable while out_valid && !out_ready.
- Boundary cases:
  - start in a non-IDLE state: ignored.
  - in_valid outside IDLE: ignored.
  - start and in_valid in the same IDLE cycle: the write lands first and is included in the block.
  - hold during OUT: no effect on the handshake.
  - Counter wrap 0xFFFFFFFF → 0: allowed, silently.
  - rst at any time: next cycle is IDLE, key/nonce/counter are zero, output pointer is zero.

## Timing
- Reset values: in_ready=1, out_valid=0, out_last=0, busy=0, out_data=0.
- start accepted at cycle 0 → first out_valid at cycle ROUNDS+2 when no hold is applied. Each hold cycle adds one cycle.
- One beat transfers per cycle when out_ready is held high. The block drains in 64·8/BUS_W cycles.
- In stream mode, the gap between out_last and the next out_valid is ROUNDS+1 cycles.
- in_ready drops the cycle after start is accepted and returns the cycle FSM enters IDLE.

## Configuration
- CHACHA_CTR64_EN defined: 64-bit counter in words 12–13 and an 8-byte nonce in words 14–15 (original DJB layout). The counter field is 8 bytes and increments mod 2^64 with a carry into word 13.
- CHACHA_CTR64_EN undefined: the IETF 32-bit counter / 12-byte nonce layout described above.

## Structure
- chacha_pkg holds:
  - the sigma constants;
  - the field-select encoding;
  - the FSM state enum;
  - the field-length constants (both layouts);
  - the state-word index constants.
- Sub-module chacha_qr: a combinational quarter-round (a,b,c,d in → a,b,c,d out). It is instantiated four times; column or diagonal routing is selected by a mux in the parent.

## Test plan
- RFC 8439 §2.3.2 (ROUNDS=20, BUS_W=8):
  - Stimulus: key 00..1f, nonce 00 00 00 09 00 00 00 4a 00 00 00 00, counter 1, start.
  - Required: out bytes 10 f1 e7 e4 d1 3b 59 15 50 0f dd 1f a3 20 71 c4 …, out_last on beat 64, first out_valid at cycle 22.
- All-zero key/nonce, counter 0, ROUNDS=20 → first bytes 76 b8 e0 ad a0 f1 3d 90.
- BUS_W=32, with the RFC vector loaded as 32-bit beats → out_data beat 0 = 0xe4e7f110; 16 beats total.
- stream=1 with the counter loaded as 0xFFFFFFFF:
  - the second block uses counter 0;
  - the gap between blocks is ROUNDS+1 cycles.
- Backpressure and hold:
  - out_ready toggled randomly → output is byte-identical and stable while stalled;
  - 5 hold cycles in ROUND → out_valid is delayed by exactly 5 cycles.
- Assert rst mid-ROUND, then start with no reload → output equals the all-zero-key vector; in_valid/start pulses outside IDLE leave state unchanged.
